// File: rtl/systolic_array_tiled.sv
// systolic_array_tiled: output-stationary ROWSxCOLS int MAC array fed by skewed TILE_K-deep tiles.
// Define SYSTOLIC_ACC_SAT_EN for sticky saturating accumulators instead of wrap-around.
module systolic_array_tiled #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int TILE_K = 4,
    parameter int DW     = 8,
    parameter int AW     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [8:0]                input_offset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [ROWS*TILE_K*DW-1:0] row_in,
    input  logic [TILE_K*COLS*DW-1:0] col_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [COLS*AW-1:0]        data_out,
    output logic                      busy
);
    localparam int XW = DW + 1;
    localparam int F  = TILE_K + ROWS + COLS - 2;
    localparam int KW = $clog2(F + 1);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [RW-1:0]             row_q, row_d;
    logic [ROWS*TILE_K*DW-1:0] a_tile_q, a_tile_d;
    logic [TILE_K*COLS*DW-1:0] b_tile_q, b_tile_d;
    logic [8:0]                off_q, off_d;
    logic                      last_q, last_d;
    logic signed [XW-1:0]      a_q [ROWS][COLS];
    logic signed [XW-1:0]      a_d [ROWS][COLS];
    logic signed [DW-1:0]      b_q [ROWS][COLS];
    logic signed [DW-1:0]      b_d [ROWS][COLS];
    logic signed [AW-1:0]      acc_q [ROWS][COLS];
    logic signed [AW-1:0]      acc_d [ROWS][COLS];
`ifdef SYSTOLIC_ACC_SAT_EN
    logic                      sat_q [ROWS][COLS];
    logic                      sat_d [ROWS][COLS];
`endif
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [COLS*AW-1:0]        data_out_q, data_out_d;
    logic                      accept;

    assign in_ready  = !rst && !clear && (state_q == IDLE || state_q == WAIT);
    assign accept    = in_valid && in_ready;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign data_out  = data_out_q;

    always_comb begin
        logic signed [XW-1:0] a_in;
        logic signed [DW-1:0] b_in;
        logic signed [AW-1:0] prod;
        logic [AW:0]          sum;
        a_in     = '0;
        b_in     = '0;
        prod     = '0;
        sum      = '0;
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        a_tile_d = a_tile_q;
        b_tile_d = b_tile_q;
        off_d    = off_q;
        last_d   = last_q;
        acc_d    = acc_q;
`ifdef SYSTOLIC_ACC_SAT_EN
        sat_d    = sat_q;
`endif
        // Skewed edge injection: row r / column c sees tile element k-r / k-c inside its window.
        for (int r = 0; r < ROWS; r++) begin
            a_in = '0;
            for (int j = 0; j < TILE_K; j++)
                if (int'(k_q) == r + j)
                    a_in = XW'(signed'(a_tile_q[(r*TILE_K+j)*DW +: DW])) + XW'(signed'(off_q));
            a_d[r][0] = (state_q == FEED) ? a_in : '0;
            for (int c = 1; c < COLS; c++) a_d[r][c] = (state_q == FEED) ? a_q[r][c-1] : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            b_in = '0;
            for (int j = 0; j < TILE_K; j++)
                if (int'(k_q) == c + j) b_in = signed'(b_tile_q[(j*COLS+c)*DW +: DW]);
            b_d[0][c] = (state_q == FEED) ? b_in : '0;
            for (int r = 1; r < ROWS; r++) b_d[r][c] = (state_q == FEED) ? b_q[r-1][c] : '0;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                prod = AW'(a_q[r][c]) * AW'(b_q[r][c]);
`ifdef SYSTOLIC_ACC_SAT_EN
                sum = {acc_q[r][c][AW-1], acc_q[r][c]} + {prod[AW-1], prod};
                sat_d[r][c] = sat_q[r][c] || (state_q == FEED && sum[AW] != sum[AW-1]);
                if (state_q == FEED && !sat_q[r][c])
                    acc_d[r][c] = (sum[AW] == sum[AW-1]) ? sum[AW-1:0] : {sum[AW], {(AW-1){!sum[AW]}}};
`else
                acc_d[r][c] = (state_q == FEED) ? acc_q[r][c] + prod : acc_q[r][c];
`endif
            end
        end
        if (accept) begin
            state_d  = FEED;
            k_d      = '0;
            a_tile_d = row_in;
            b_tile_d = col_in;
            off_d    = input_offset;
            last_d   = in_last;
        end else if (state_q == FEED) begin
            k_d = k_q + KW'(1);
            // k == F is the settle cycle that retires the last product.
            if (k_q == KW'(F)) begin
                state_d = last_q ? DRAIN : WAIT;
                k_d     = '0;
                row_d   = '0;
            end
        end else if (state_q == DRAIN && out_valid_q && out_ready) begin
            row_d = row_q + RW'(1);
            if (row_q == RW'(ROWS - 1)) begin
                state_d = IDLE;
                row_d   = '0;
                acc_d   = '{default: '0};
`ifdef SYSTOLIC_ACC_SAT_EN
                sat_d   = '{default: '0};
`endif
            end
        end
        if (clear) begin
            state_d  = IDLE;
            k_d      = '0;
            row_d    = '0;
            a_tile_d = '0;
            b_tile_d = '0;
            off_d    = '0;
            last_d   = 1'b0;
            a_d      = '{default: '0};
            b_d      = '{default: '0};
            acc_d    = '{default: '0};
`ifdef SYSTOLIC_ACC_SAT_EN
            sat_d    = '{default: '0};
`endif
        end
        out_valid_d = state_d == DRAIN;
        out_last_d  = out_valid_d && row_d == RW'(ROWS - 1);
        data_out_d  = '0;
        if (out_valid_d)
            for (int c = 0; c < COLS; c++) data_out_d[c*AW +: AW] = acc_d[row_d][c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            row_q       <= '0;
            a_tile_q    <= '0;
            b_tile_q    <= '0;
            off_q       <= '0;
            last_q      <= 1'b0;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            acc_q       <= '{default: '0};
`ifdef SYSTOLIC_ACC_SAT_EN
            sat_q       <= '{default: '0};
`endif
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            a_tile_q    <= a_tile_d;
            b_tile_q    <= b_tile_d;
            off_q       <= off_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
`ifdef SYSTOLIC_ACC_SAT_EN
            sat_q       <= sat_d;
`endif
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            data_out_q  <= data_out_d;
        end
    end
endmodule
